hamming_rx_stage: RTL and testbench

HAMMING_RX_STAGE -- requirements
Module: hamming_rx_stage

---
 rtl/hamming_pkg.sv | 50 +++++
 rtl/button_debounce.sv | 58 +++++
 rtl/hamming_rx_stage.sv | 128 ++++++++++++
 tb/tb_hamming_rx_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming(7,4) receive stage.
// Contents: FSM state enum, codeword/nibble/syndrome typedefs, code-position
// bit indices, and pure functions for syndrome, correction and data extraction.
package hamming_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  typedef logic [6:0] codeword_t;
  typedef logic [3:0] nibble_t;
  typedef logic [2:0] syndrome_t;

  // Bit index inside codeword_t of code position k (position k lives at bit k-1).
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D1 = 2;
  localparam int POS_P3 = 3;
  localparam int POS_D2 = 4;
  localparam int POS_D3 = 5;
  localparam int POS_D4 = 6;

  // Parity checks over positions 1,3,5,7 / 2,3,6,7 / 4,5,6,7.
  function automatic syndrome_t calc_syndrome(input codeword_t c);
    logic s1, s2, s3;
    s1 = c[POS_P1] ^ c[POS_D1] ^ c[POS_D2] ^ c[POS_D4];
    s2 = c[POS_P2] ^ c[POS_D1] ^ c[POS_D3] ^ c[POS_D4];
    s3 = c[POS_P3] ^ c[POS_D2] ^ c[POS_D3] ^ c[POS_D4];
    return {s3, s2, s1};
  endfunction

  // Flip the position named by the syndrome; syndrome 0 leaves the word intact.
  function automatic codeword_t correct_word(input codeword_t c, input syndrome_t s);
    codeword_t mask;
    if (s == 3'd0) begin
      mask = 7'd0;
    end else begin
      mask = 7'd1 << (s - 3'd1);
    end
    return c ^ mask;
  endfunction

  // Data nibble {d4,d3,d2,d1}.
  function automatic nibble_t extract_data(input codeword_t c);
    return {c[POS_D4], c[POS_D3], c[POS_D2], c[POS_D1]};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and rising-edge detector on the accepted level.
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   btn_raw   - raw asynchronous button input
//   btn_rise  - one-cycle registered pulse on each accepted 0->1 transition
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_r;
  logic             cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             rise_r;

  // Synchronizer, stable-level counter, accepted level and rise pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r  <= 2'b00;
      cand_r  <= 1'b0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
      // Any change of the synchronized level restarts the stability count.
      if (sync_r[1] != cand_r) begin
        cand_r <= sync_r[1];
        cnt_r  <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      // Candidate has been stable long enough: it becomes the accepted level.
      if ((sync_r[1] == cand_r) && (cnt_r == CNT_MAX)) begin
        level_r <= cand_r;
        rise_r  <= cand_r & ~level_r;
      end else begin
        level_r <= level_r;
        rise_r  <= 1'b0;
      end
    end
  end

  assign btn_rise = rise_r;

endmodule

// File: rtl/hamming_rx_stage.sv
// Hamming(7,4) receive stage: captures a codeword, registers its syndrome,
// then publishes the single-bit-corrected nibble and error position. A separate
// debounced push-button path toggles the display-select output.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   code_in         - received codeword (bit k-1 = code position k)
//   code_valid      - code_in valid; accepted only when code_ready is high
//   code_ready      - high only while idle
//   mode_btn        - raw display-mode button
//   corrected_data  - decoded nibble {d4,d3,d2,d1}
//   error_position  - syndrome (0 = no error)
//   error_flag      - error_position != 0
//   data_valid      - one-cycle pulse on each result update
//   switch_mode     - display select, 0 = data, 1 = error position
module hamming_rx_stage
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic       mode_btn,
  output logic [3:0] corrected_data,
  output logic [2:0] error_position,
  output logic       error_flag,
  output logic       data_valid,
  output logic       switch_mode
);

  state_e    state_r, next_state_s;
  codeword_t word_r;
  syndrome_t syndrome_r;
  logic      ready_r;
  nibble_t   data_r;
  syndrome_t pos_r;
  logic      flag_r;
  logic      valid_r;
  logic      mode_r;
  logic      accept_s;
  logic      btn_rise_s;

  assign accept_s = code_valid & ready_r;

  // Next-state logic for the capture/decode/update sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_DECODE: next_state_s = S_UPDATE;
      S_UPDATE: next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Codeword datapath, FSM state and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      word_r     <= 7'd0;
      syndrome_r <= 3'd0;
      ready_r    <= 1'b0;
      data_r     <= 4'd0;
      pos_r      <= 3'd0;
      flag_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      // Ready is registered from the next state so it is low during reset.
      ready_r <= (next_state_s == S_IDLE);
      if ((state_r == S_IDLE) && accept_s) begin
        word_r <= code_in;
      end else begin
        word_r <= word_r;
      end
      if (state_r == S_DECODE) begin
        syndrome_r <= calc_syndrome(word_r);
      end else begin
        syndrome_r <= syndrome_r;
      end
      if (state_r == S_UPDATE) begin
        data_r  <= extract_data(correct_word(word_r, syndrome_r));
        pos_r   <= syndrome_r;
        flag_r  <= (syndrome_r != 3'd0);
        valid_r <= 1'b1;
      end else begin
        data_r  <= data_r;
        pos_r   <= pos_r;
        flag_r  <= flag_r;
        valid_r <= 1'b0;
      end
    end
  end

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (mode_btn),
    .btn_rise (btn_rise_s)
  );

  // Display-select toggle on each accepted button press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else begin
      mode_r <= mode_r ^ btn_rise_s;
    end
  end

  assign code_ready     = ready_r;
  assign corrected_data = data_r;
  assign error_position = pos_r;
  assign error_flag     = flag_r;
  assign data_valid     = valid_r;
  assign switch_mode    = mode_r;

endmodule

// File: tb/tb_hamming_rx_stage.sv
// Scoreboard bench for hamming_rx_stage: the driver pushes hand-computed
// expectations on each handshake; a monitor pops and compares on data_valid.
module tb_hamming_rx_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] code_in = 7'd0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic       mode_btn = 1'b0;
  logic [3:0] corrected_data;
  logic [2:0] error_position;
  logic       error_flag;
  logic       data_valid;
  logic       switch_mode;

  typedef struct {
    logic [3:0] d;
    logic [2:0] p;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;

  hamming_rx_stage #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .code_in        (code_in),
    .code_valid     (code_valid),
    .code_ready     (code_ready),
    .mode_btn       (mode_btn),
    .corrected_data (corrected_data),
    .error_position (error_position),
    .error_flag     (error_flag),
    .data_valid     (data_valid),
    .switch_mode    (switch_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_valid sample must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      if (q.size() == 0) begin
        check("unexpected_data_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("corrected_data", int'(corrected_data), int'(e.d));
        check("error_position", int'(error_position), int'(e.p));
        check("error_flag", int'(error_flag), int'(e.p != 3'd0));
        check("result_latency", cyc - e.acc, 2);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [6:0] c, input logic [3:0] d, input logic [2:0] p,
                      input bit keep_valid);
    int t;
    exp_t e;
    t = 0;
    code_in = c;
    code_valid = 1'b1;
    while (!code_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!code_ready) begin
      check("handshake_timeout", 0, 1);
      code_valid = 1'b0;
    end else begin
      e.d = d;
      e.p = p;
      e.acc = cyc + 1;
      last_acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (!keep_valid) code_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input int n);
    mode_btn = 1'b1;
    repeat (n) @(negedge clk);
    mode_btn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  logic [6:0] vec_c [7] = '{7'h54, 7'h57, 7'h51, 7'h5D, 7'h45, 7'h75, 7'h15};

  initial begin
    int first_acc;
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_code_ready", int'(code_ready), 0);
    check("reset_data_valid", int'(data_valid), 0);
    check("reset_corrected_data", int'(corrected_data), 0);
    check("reset_error_position", int'(error_position), 0);
    check("reset_error_flag", int'(error_flag), 0);
    check("reset_switch_mode", int'(switch_mode), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(code_ready), 1);

    // Clean words and single-bit errors at every position
    send(7'h55, 4'hB, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    send(7'h00, 4'h0, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    send(7'h7F, 4'hF, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      send(vec_c[k], 4'hB, 3'(k + 1), 1'b0);
      repeat (3) @(negedge clk);
    end
    // Double-bit error (positions 1,2) miscorrects position 3
    send(7'h56, 4'hA, 3'd3, 1'b0);
    repeat (3) @(negedge clk);
    // Result holds between updates
    check("hold_corrected_data", int'(corrected_data), 10);
    check("hold_error_position", int'(error_position), 3);

    // Back-to-back with code_valid held high
    send(7'h55, 4'hB, 3'd0, 1'b1);
    first_acc = last_acc;
    check("ready_low_after_accept", int'(code_ready), 0);
    send(7'h45, 4'hB, 3'd5, 1'b0);
    check("accept_spacing", last_acc - first_acc, 3);
    repeat (4) @(negedge clk);

    // Debounce / toggle
    press(3);
    check("glitch_no_toggle", int'(switch_mode), 0);
    press(10);
    check("press1_toggle", int'(switch_mode), 1);
    press(10);
    check("press2_toggle", int'(switch_mode), 0);
    press(10);
    check("press3_toggle", int'(switch_mode), 1);

    // Reset while a word is in S_DECODE: word aborted, no pulse
    send(7'h55, 4'hB, 3'd0, 1'b0);
    q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_code_ready", int'(code_ready), 0);
    check("abort_corrected_data", int'(corrected_data), 0);
    check("abort_error_position", int'(error_position), 0);
    check("abort_error_flag", int'(error_flag), 0);
    check("abort_switch_mode", int'(switch_mode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", int'(code_ready), 1);
    repeat (6) @(negedge clk);

    // Drain
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
